// File: rtl/ysyx_210544_bus_arbiter_pkg.sv
// Shared definitions for the fetch/memory bus arbiter: FSM state encodings,
// bus transfer size codes, bus widths and the grantee tag used for round-robin.
package ysyx_210544_bus_arbiter_pkg;

  localparam int BUS_32 = 32;
  localparam int BUS_64 = 64;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_GRANT_IF  = 2'd1,
    ARB_GRANT_MEM = 2'd2
  } arb_state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  // Which requester owned the most recent grant; a tie goes to the other one.
  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } grantee_e;

  // Select the 32-bit instruction word out of a 64-bit bus beat.
  function automatic logic [BUS_32-1:0] pick_word(input logic sel_hi,
                                                  input logic [BUS_64-1:0] beat);
    return sel_hi ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/ysyx_210544_bus_arbiter_if.sv
// Requester-side and bus-side signals of the arbiter, bundled as one interface.
// master: the arbiter's view (drives acks, read data and the downstream bus).
// slave:  the environment's view (requesters plus the AXI bridge).
interface ysyx_210544_bus_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [31:0]       if_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        mem_size;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [1:0]        bus_size;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  logic              o_busy;
  logic              o_timeout;

  modport master (
    input  if_req, if_addr,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_size,
    input  bus_ack, bus_rdata,
    output if_ack, if_rdata,
    output mem_ack, mem_rdata,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_size,
    output o_busy, o_timeout
  );

  modport slave (
    output if_req, if_addr,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_size,
    output bus_ack, bus_rdata,
    input  if_ack, if_rdata,
    input  mem_ack, mem_rdata,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_size,
    input  o_busy, o_timeout
  );
endinterface

// File: rtl/ysyx_210544_bus_watchdog.sv
// Grant watchdog: counts cycles while enabled, cleared by clr, and flags
// expire in the cycle where the count has reached TIMEOUT-1 while still enabled.
module ysyx_210544_bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt;

  // Clear has priority; otherwise count enabled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ysyx_210544_bus_arbiter.sv
// Round-robin arbiter between instruction fetch and memory access for the
// single core bus port. One transaction is latched at a time into registered
// bus outputs; acknowledge and read data are routed back combinationally.
module ysyx_210544_bus_arbiter
  import ysyx_210544_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input logic                          clk,
  input logic                          rst,
  ysyx_210544_bus_arbiter_if.master    arb
);

  arb_state_e        state;
  arb_state_e        state_n;
  grantee_e          last_grant;

  logic              bus_req_r;
  logic              bus_we_r;
  logic [ADDR_W-1:0] bus_addr_r;
  logic [DATA_W-1:0] bus_wdata_r;
  logic [1:0]        bus_size_r;
  logic              timeout_r;

  logic              grant_if;
  logic              grant_mem;
  logic              done;
  logic              wd_hit;
  logic              if_ack_c;
  logic              mem_ack_c;

  logic              wd_clr;
  logic              wd_en;
  logic              expire;

  // Counter runs only while a grant waits for its acknowledge.
  assign wd_clr = (state == ARB_IDLE);
  assign wd_en  = (state != ARB_IDLE) && !arb.bus_ack;

  ysyx_210544_bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Arbitration, completion detection and acknowledge generation.
  always_comb begin
    state_n   = state;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    done      = 1'b0;
    wd_hit    = 1'b0;
    if_ack_c  = 1'b0;
    mem_ack_c = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (arb.if_req && arb.mem_req) begin
          if (last_grant == GNT_IF) grant_mem = 1'b1;
          else                      grant_if  = 1'b1;
        end else if (arb.if_req) begin
          grant_if = 1'b1;
        end else if (arb.mem_req) begin
          grant_mem = 1'b1;
        end
        if (grant_if)       state_n = ARB_GRANT_IF;
        else if (grant_mem) state_n = ARB_GRANT_MEM;
      end
      ARB_GRANT_IF: begin
        if (arb.bus_ack || expire) begin
          if_ack_c = 1'b1;
          done     = 1'b1;
          wd_hit   = !arb.bus_ack;
          state_n  = ARB_IDLE;
        end
      end
      ARB_GRANT_MEM: begin
        if (arb.bus_ack || expire) begin
          mem_ack_c = 1'b1;
          done      = 1'b1;
          wd_hit    = !arb.bus_ack;
          state_n   = ARB_IDLE;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  // Latch the granted transaction, track round-robin owner and sticky timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= '0;
      bus_wdata_r <= '0;
      bus_size_r  <= SIZE_B;
      last_grant  <= GNT_IF;
      timeout_r   <= 1'b0;
    end else begin
      if (grant_if) begin
        bus_req_r   <= 1'b1;
        bus_we_r    <= 1'b0;
        bus_addr_r  <= arb.if_addr;
        bus_wdata_r <= '0;
        bus_size_r  <= SIZE_W;
        last_grant  <= GNT_IF;
      end else if (grant_mem) begin
        bus_req_r   <= 1'b1;
        bus_we_r    <= arb.mem_we;
        bus_addr_r  <= arb.mem_addr;
        bus_wdata_r <= arb.mem_wdata;
        bus_size_r  <= arb.mem_size;
        last_grant  <= GNT_MEM;
      end else if (done) begin
        bus_req_r   <= 1'b0;
      end
      if (wd_hit) begin
        timeout_r <= 1'b1;
      end
    end
  end

  assign arb.bus_req   = bus_req_r;
  assign arb.bus_we    = bus_we_r;
  assign arb.bus_addr  = bus_addr_r;
  assign arb.bus_wdata = bus_wdata_r;
  assign arb.bus_size  = bus_size_r;
  assign arb.o_busy    = (state != ARB_IDLE);
  assign arb.o_timeout = timeout_r;

  // Return path: read data only on a real bus ack, zero on a watchdog kill.
  assign arb.if_ack    = if_ack_c;
  assign arb.mem_ack   = mem_ack_c;
  assign arb.if_rdata  = (if_ack_c && arb.bus_ack)
                         ? pick_word(bus_addr_r[2], arb.bus_rdata) : '0;
  assign arb.mem_rdata = (mem_ack_c && arb.bus_ack) ? arb.bus_rdata : '0;

endmodule

// File: doc/ysyx_210544_bus_arbiter.md
# ysyx_210544_bus_arbiter

Two-requester arbiter sharing the core's single memory bus port between the fetch unit (read-only, 32-bit instructions) and the memory-access stage (64-bit loads/stores). It sits between both requesters and the AXI bridge, and latches one transaction at a time into registered bus outputs. It forwards the bus acknowledge and read data back to the granted requester, and a watchdog terminates hung transactions.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, bus data width
- TIMEOUT, 255, max cycles in a grant before forced termination (≥2)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request level
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  fetch done pulse
- if_rdata  out  32  instruction word
- mem_req  in  1  data request level
- mem_we  in  1  1 = store
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_size  in  2  0=byte 1=half 2=word 3=dword
- mem_ack  out  1  data done pulse
- mem_rdata  out  DATA_W  load data
- bus_req  out  1  downstream request, registered
- bus_we, bus_addr, bus_wdata, bus_size  out  1/ADDR_W/DATA_W/2  latched transaction, registered
- bus_ack  in  1  downstream done pulse
- bus_rdata  in  DATA_W  downstream read data, valid with bus_ack
- o_busy  out  1  state ≠ IDLE
- o_timeout  out  1  sticky watchdog flag

## Operation
- States: IDLE, GRANT_IF, GRANT_MEM.
- IDLE: both requests low → stay. One high → grant it. Both high → grant the one not in last_grant (round-robin); last_grant resets to IF, so MEM wins the first tie.
- On grant: latch requester's fields into bus_*, bus_req←1, last_grant←grantee, clear watchdog counter. IF grant: bus_we=0, bus_size=2, bus_wdata=0.
- GRANT_x, bus_ack=1: x_ack=1 combinationally same cycle; next state IDLE, bus_req←0.
- if_rdata = latched bus_addr[2] ? bus_rdata[63:32] : bus_rdata[31:0]; mem_rdata = bus_rdata (passthrough). Both outputs 0 when their ack is low.
- Requester inputs are ignored outside IDLE; changes during a grant do not alter bus_*.
- Watchdog: counter increments each GRANT cycle without bus_ack. When it reaches TIMEOUT-1 with no ack: fake x_ack=1, rdata=0, o_timeout←1 (sticky until rst), next state IDLE, bus_req←0. A bus_ack arriving on that same cycle is treated as a normal completion; o_timeout is not set.
- Acks are never issued in IDLE. At most one of if_ack/mem_ack is high per cycle.

## Timing
- Reset (async): state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_size=0, last_grant=IF, counter=0, o_timeout=0, o_busy=0, acks 0.
- Request sampled at edge N in IDLE → bus_req=1 from cycle N+1.
- bus_ack in cycle M → requester ack in cycle M (zero latency). Arbiter is IDLE at M+1, and the next grant has bus_req=1 at M+2 at the earliest.
- Requester must drop its req at the edge after its ack. A req still high in IDLE is a new transaction.
- Reset mid-grant: bus_req drops immediately, and the transaction is abandoned without any ack.

## Structure
- The shared defines file holds the state encodings (ARB_IDLE/ARB_GRANT_IF/ARB_GRANT_MEM), size codes (SIZE_B/H/W/D), and the existing BUS_32/BUS_64 widths.
- One sub-module: ysyx_210544_bus_watchdog. It is a clear/enable counter that outputs an expire pulse at TIMEOUT-1.
- The FSM, latch registers and return-path muxing live in the top module.

## Test plan
- Lone fetch: if_req=1, if_addr=0x8000_0004, bus_ack at cycle 3 with bus_rdata=0x1111_2222_3333_4444 → bus_addr=0x8000_0004, bus_size=2, bus_we=0, if_ack at cycle 3, if_rdata=0x1111_2222, IDLE at cycle 4.
- Tie: if_req and mem_req rise together, twice in succession → first grant MEM, second IF; after the first ack, the IF grant shows bus_req=1 two cycles later.
- Store: mem_we=1, mem_addr=0x8000_1000, mem_wdata=0xDEAD_BEEF, mem_size=3 → bus_* carry exactly those values; mem_ack only on bus_ack; if_ack stays 0.
- Timeout: grant IF with no bus_ack and TIMEOUT=8 → if_ack=1, if_rdata=0 on the 8th grant cycle, o_timeout=1 and stays set, next grant proceeds normally.
- Ack on the expire cycle: bus_ack coincides with expire → normal completion, o_timeout=0.
- Async reset mid-grant: assert rst between edges during GRANT_MEM → bus_req=0 before the next edge, no mem_ack, state IDLE after rst release.
